// File: rtl/mdu_iter_unit.sv
// mdu_iter_unit
// Iterative multiply/divide unit sitting beside the single-cycle ALU in EX.
// It executes mult, multu, div and divu, keeps the architectural HI/LO
// registers and accepts mthi/mtlo writes while idle. The pipeline stalls
// while busy is high.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start            operation request, accepted only in IDLE
//   op               00 mult, 01 multu, 10 div, 11 divu (sampled with start)
//   src_a, src_b     multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we     mthi/mtlo write enables (IDLE only), data on wdata
//   busy             operation in flight (RUN/FIX)
//   done             one-cycle pulse in the cycle HI/LO show a new result
//   div_zero         sticky divide-by-zero flag, cleared by the next start
//   hi, lo           HI and LO registers
//
// Configuration macro: MDU_EARLY_OUT_EN lets multiplies leave RUN as soon as
// the unprocessed multiplier bits are all zero.
//
// Timing: start seen in cycle T gives RUN in T+1..T+WIDTH, FIX in T+WIDTH+1
// and DONE in T+WIDTH+2. HI/LO are loaded on the FIX->DONE edge so they are
// valid in the done cycle. A zero divisor skips the iterations and goes from
// IDLE through FIX to DONE, so done appears in T+2.
`timescale 1ns/1ps
module mdu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's complement negation at WIDTH bits.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation at 2*WIDTH bits.
    function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
        return ~v + {{(W2-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;      // mult: product; div: {remainder, dividend/quotient}
    logic [W2-1:0]    a_q, a_d;          // mult: shifted multiplicand; div-by-zero: raw dividend
    logic [WIDTH-1:0] b_q, b_d;          // mult: multiplier (shifts right); div: divisor magnitude
    logic             op_div_q, op_div_d;
    logic             neg_res_q, neg_res_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [W2:0]      sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_sub_s;
    logic [W2-1:0]    prod_sum_s;
    logic [W2-1:0]    prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
    logic             last_iter_s;

    // Signed ops work on magnitudes; the result signs are applied in FIX.
    assign a_neg_s = ~op[0] & src_a[WIDTH-1];
    assign b_neg_s = ~op[0] & src_b[WIDTH-1];
    assign mag_a_s = a_neg_s ? neg_w(src_a) : src_a;
    assign mag_b_s = b_neg_s ? neg_w(src_b) : src_b;

    // Restoring divide step: shift {rem, dividend} left, trial-subtract at WIDTH+1 bits.
    assign sh_s      = {acc_q, 1'b0};
    assign ge_s      = (sh_s[W2:WIDTH] >= {1'b0, b_q});
    assign rem_sub_s = sh_s[W2-1:WIDTH] - b_q;

    // Shift-add multiply step.
    assign prod_sum_s = acc_q + (b_q[0] ? a_q : {W2{1'b0}});

    assign prod_fix_s = neg_res_q ? neg_2w(acc_q) : acc_q;
    assign quo_fix_s  = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix_s  = rem_neg_q ? neg_w(acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
    // A multiply may stop once no set multiplier bits remain above the current one.
    assign last_iter_s = (cnt_q == LAST_CNT) ||
                         (!op_div_q && (b_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
`else
    assign last_iter_s = (cnt_q == LAST_CNT);
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    op_div_d  = op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    rem_neg_d = a_neg_s;
                    cnt_d     = {CNT_W{1'b0}};
                    if (op[1] && (src_b == {WIDTH{1'b0}})) begin
                        dz_d       = 1'b1;
                        div_zero_d = 1'b1;
                        acc_d      = {W2{1'b0}};
                        a_d        = {{WIDTH{1'b0}}, src_a};
                        b_d        = src_b;
                        state_d    = S_FIX;
                    end else if (op[1]) begin
                        dz_d       = 1'b0;
                        div_zero_d = 1'b0;
                        acc_d      = {{WIDTH{1'b0}}, mag_a_s};
                        a_d        = {W2{1'b0}};
                        b_d        = mag_b_s;
                        state_d    = S_RUN;
                    end else begin
                        dz_d       = 1'b0;
                        div_zero_d = 1'b0;
                        acc_d      = {W2{1'b0}};
                        a_d        = {{WIDTH{1'b0}}, mag_a_s};
                        b_d        = mag_b_s;
                        state_d    = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (op_div_q) begin
                    if (ge_s) begin
                        acc_d = {rem_sub_s, sh_s[WIDTH-1:1], 1'b1};
                    end else begin
                        acc_d = sh_s[W2-1:0];
                    end
                end else begin
                    acc_d = prod_sum_s;
                    a_d   = {a_q[W2-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_iter_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    hi_d = a_q[WIDTH-1:0];
                    lo_d = {WIDTH{1'b1}};
                end else if (op_div_q) begin
                    // Most-negative / -1 falls out naturally: quotient wraps, remainder 0.
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[W2-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {W2{1'b0}};
            a_q        <= {W2{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
`timescale 1ns/1ps
module tb_mdu_iter_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    mdu_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model built on the simulator's own 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, q, r;
        logic [63:0] pv, qv, rv;
        if (o[0]) begin
            sa  = {32'd0, a};
            sbv = {32'd0, b};
        end else begin
            sa  = $signed(a);
            sbv = $signed(b);
        end
        e.dz  = 1'b0;
        e.lat = W + 2;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        if (!o[1]) begin
            p = sa * sbv;
            pv = p;
            e.hi = pv[63:32];
            e.lo = pv[31:0];
`ifdef MDU_EARLY_OUT_EN
            begin
                longint mb;
                logic [63:0] mbv;
                int k;
                mb = (sbv < 0) ? -sbv : sbv;
                mbv = mb;
                k = 1;
                for (int i = 0; i < W; i++) begin
                    if (mbv[i]) k = i + 1;
                end
                e.lat = k + 2;
            end
`endif
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            qv = q;
            rv = r;
            e.hi = rv[31:0];
            e.lo = qv[31:0];
        end
        return e;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   cyc;
        sb_q.push_back(model(o, a, b));
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        if (sb_q[$].dz == 1'b0) begin
            checks++;
            if (div_zero !== 1'b0) begin
                errors++;
                $display("FAIL %s div_zero_cleared: got %b expected 0", name, div_zero);
            end
        end
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, expected at %0d", name, cyc, e.lat);
        end else begin
            if (cyc !== e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
            end
            checks++;
            if (hi !== e.hi) begin
                errors++;
                $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
            end
            checks++;
            if (lo !== e.lo) begin
                errors++;
                $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
            end
            checks++;
            if (div_zero !== e.dz) begin
                errors++;
                $display("FAIL %s div_zero: got %b expected %b", name, div_zero, e.dz);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1; op = 2'($urandom_range(0, 3));
        src_a = $urandom; src_b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'd2);
        run_op("multu_9x3", 2'b01, 32'd9, 32'd3);
        run_op("mult_mostneg_sq", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("multu_by_zero", 2'b01, 32'h1234_5678, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op("mult_rand", 2'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    task automatic test_div;
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_mostneg_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_small_big", 2'b11, 32'd5, 32'hFFFF_FFF0);
        for (int i = 0; i < 4; i++) begin
            run_op("div_rand", 2'($urandom_range(2, 3)), $urandom, $urandom | 32'd1);
        end
    endtask

    task automatic test_div_zero;
        run_op("divu_by_zero", 2'b11, 32'h0000_1234, 32'd0);
        run_op("after_div_zero", 2'b01, 32'd6, 32'd7);
        run_op("div_by_zero_signed", 2'b10, 32'h8765_4321, 32'd0);
        run_op("div_after_zero", 2'b10, 32'd21, 32'd4);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc, n_done, first;
        sb_q.push_back(model(2'b01, 32'h0001_0003, 32'h0000_0101));
        op = 2'b01; src_a = 32'h0001_0003; src_b = 32'h0000_0101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; n_done = 0; first = 0;
        while (cyc < 45) begin
            if (done === 1'b1) begin
                n_done++;
                if (first == 0) first = cyc;
            end
            if (cyc == 5) begin start = 1'b1; op = 2'b11; src_a = 32'h0000_0077; src_b = 32'd0; end
            if (cyc == 6) start = 1'b0;
            if (cyc == 10) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (cyc == 11) hi_we = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        checks++; if (n_done !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
        checks++; if (first !== e.lat) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected %0d", first, e.lat); end
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo, e.lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL b2b_div_zero: got %b expected 0", div_zero); end

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_mtlo_hi: got %h expected a5a5a5a5", hi); end
        checks++; if (lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_mtlo_lo: got %h expected a5a5a5a5", lo); end
        lo_we = 1'b1; wdata = 32'h0F0F_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo_only_hi: got %h expected a5a5a5a5", hi); end
        checks++; if (lo !== 32'h0F0F_1234) begin errors++; $display("FAIL mtlo_only_lo: got %h expected 0f0f1234", lo); end
    endtask

    task automatic test_abort;
        int cyc, n_done;
        sb_q.push_back(model(2'b10, 32'd100, 32'd7));
        op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; n_done = 0;
        while (cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) n_done++;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h expected 0", lo); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (i == 3) rst_n = 1'b1;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
        void'(sb_q.pop_front());
        run_op("div_after_abort", 2'b10, 32'd100, 32'd7);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00;
        src_a = 32'd0; src_b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_abort();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
